// File: rtl/mul_result_collector.sv
// Receiving end of the fixed-latency multiplier cascade. Hands out launch
// credits, buffers every result in a FWFT FIFO and returns a credit per pop.
module mul_result_collector #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 8,
   parameter int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             launch_valid,
   output logic             launch_ready,
   input  logic             res_valid,
   input  logic [WIDTH-1:0] res_data,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   input  logic             out_ready,
   output logic [CNT_W-1:0] credits,
   output logic [CNT_W-1:0] count,
   output logic             overflow
);

   localparam int              AW       = $clog2(DEPTH);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [AW:0]      PTR_ONE  = (AW + 1)'(1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic [CNT_W-1:0] credit_q;
   logic [CNT_W-1:0] credit_d;
   logic             full;
   logic             launch_fire;
   logic             pop;
   logic             push_ok;

   // The extra pointer MSB separates full (same index, MSBs differ) from empty.
   assign count        = CNT_W'(wr_ptr - rd_ptr);
   assign full         = (count == FULL_CNT);
   assign out_valid    = (count != '0);
   assign out_data     = out_valid ? mem[rd_ptr[AW-1:0]] : '0;
   assign credits      = credit_q;
   assign launch_ready = rst & (credit_q != '0);

   assign launch_fire  = launch_valid & launch_ready;
   assign pop          = out_valid & out_ready;
   // A same-cycle pop frees the head slot, so a push into a full FIFO still lands.
   assign push_ok      = res_valid & (~full | pop);

   always_comb begin
      // NOTE: default first, so every path assigns credit_d and no latch is inferred.
      credit_d = credit_q;
      if (launch_fire && !pop) begin
         credit_d = credit_q - CNT_ONE;
      end else if (pop && !launch_fire && credit_q != FULL_CNT) begin
         credit_d = credit_q + CNT_ONE;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         credit_q <= FULL_CNT;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         overflow <= 1'b0;
      end else begin
         credit_q <= credit_d;
         if (push_ok) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_ONE;
         end
         if (res_valid && full && !pop) begin
            overflow <= 1'b1;
         end
      end
   end

   // NOTE: the storage array has no reset; empty pointers already mask its contents.
   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem[wr_ptr[AW-1:0]] <= res_data;
      end
   end

endmodule

// File: tb/tb_mul_result_collector.sv
// Self-checking bench: queue-based model of credits, cascade and FIFO, with
// directed phases plus a randomized launch/drain phase.
module tb_mul_result_collector;

   localparam int WIDTH = 32;
   localparam int DEPTH = 8;
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int LAT   = 4;

   typedef struct {
      int               due;
      logic [WIDTH-1:0] data;
   } flight_t;

   logic             clk = 1'b0;
   logic             rst;
   logic             launch_valid;
   logic             launch_ready;
   logic             res_valid;
   logic [WIDTH-1:0] res_data;
   logic             out_valid;
   logic [WIDTH-1:0] out_data;
   logic             out_ready;
   logic [CNT_W-1:0] credits;
   logic [CNT_W-1:0] count;
   logic             overflow;

   int               tests = 0;
   int               fails = 0;
   int               m_credits;
   logic             m_ovf;
   logic [WIDTH-1:0] m_fifo[$];
   flight_t          pipe[$];
   int               cyc = 0;
   bit               honor = 1'b1;
   bit               seq_data = 1'b1;
   logic [WIDTH-1:0] l_data = 32'h11;

   mul_result_collector #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk          (clk),
      .rst          (rst),
      .launch_valid (launch_valid),
      .launch_ready (launch_ready),
      .res_valid    (res_valid),
      .res_data     (res_data),
      .out_valid    (out_valid),
      .out_data     (out_data),
      .out_ready    (out_ready),
      .credits      (credits),
      .count        (count),
      .overflow     (overflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock cycle: check outputs against the model, clock, then advance the model.
   task automatic cycle();
      bit fire, pop, push;
      #1;
      chk("launch_ready", launch_ready, m_credits != 0);
      chk("credits", credits, m_credits);
      chk("count", count, m_fifo.size());
      chk("out_valid", out_valid, m_fifo.size() != 0);
      if (m_fifo.size() != 0) chk("out_data", out_data, m_fifo[0]);
      chk("overflow", overflow, m_ovf);
      if (honor) chk("invariant", credits + count + pipe.size() + res_valid, DEPTH);
      fire = launch_valid && (m_credits != 0);
      pop  = out_ready && (m_fifo.size() != 0);
      push = res_valid;
      if (honor && pop) chk("pop_at_full_credit", credits == DEPTH, 0);
      @(posedge clk);
      #1;
      if (pop) void'(m_fifo.pop_front());
      if (push) begin
         if (m_fifo.size() < DEPTH) m_fifo.push_back(res_data);
         else m_ovf = 1'b1;
      end
      m_credits = m_credits - int'(fire) + int'(pop);
      if (m_credits > DEPTH) m_credits = DEPTH;
      if (fire) begin
         pipe.push_back('{cyc + LAT, l_data});
         l_data = seq_data ? l_data + 1 : $urandom;
      end
      cyc++;
      res_valid = 1'b0;
      if (pipe.size() != 0 && pipe[0].due <= cyc) begin
         res_valid = 1'b1;
         res_data  = pipe[0].data;
         void'(pipe.pop_front());
      end
   endtask

   task automatic do_reset(input logic lv);
      rst          = 1'b0;
      launch_valid = lv;
      out_ready    = 1'b0;
      res_valid    = 1'b0;
      res_data     = '0;
      pipe.delete();
      m_fifo.delete();
      m_credits = DEPTH;
      m_ovf     = 1'b0;
      repeat (3) begin
         @(negedge clk);
         chk("rst_launch_ready", launch_ready, 0);
         chk("rst_credits", credits, DEPTH);
         chk("rst_count", count, 0);
         chk("rst_out_valid", out_valid, 0);
         chk("rst_overflow", overflow, 0);
      end
      @(posedge clk);
      #1;
      rst          = 1'b1;
      launch_valid = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b0; launch_valid = 1'b0; out_ready = 1'b0; res_valid = 1'b0; res_data = '0;
      do_reset(1'b1);

      // Credit exhaustion with a 4-cycle cascade; results 0x11..0x18.
      launch_valid = 1'b1;
      repeat (20) cycle();
      launch_valid = 1'b0;
      chk("exhaust_count", count, DEPTH);
      chk("exhaust_credits", credits, 0);

      // In-order drain; credits climb back one cycle behind each pop.
      out_ready = 1'b1;
      repeat (12) cycle();
      out_ready = 1'b0;
      chk("drain_credits", credits, DEPTH);

      // Randomized launches and back-pressure.
      seq_data = 1'b0;
      l_data   = $urandom;
      repeat (300) begin
         launch_valid = 1'($urandom_range(0, 1));
         out_ready    = ($urandom_range(0, 3) != 0);
         cycle();
      end
      launch_valid = 1'b0;
      out_ready    = 1'b1;
      repeat (20) cycle();
      chk("random_final_credits", credits, DEPTH);
      chk("random_final_count", count, 0);

      // Full FIFO, extra result arrives together with a pop.
      do_reset(1'b0);
      launch_valid = 1'b1;
      repeat (16) cycle();
      launch_valid = 1'b0;
      honor = 1'b0;
      res_valid = 1'b1; res_data = 32'hA5A5_0001; out_ready = 1'b1;
      cycle();
      out_ready = 1'b0;
      cycle();
      chk("full_pushpop_count", count, DEPTH);
      chk("full_pushpop_overflow", overflow, 0);

      // Overflow: result into a full FIFO with no pop is dropped and flagged.
      res_valid = 1'b1; res_data = 32'hDEAD_BEEF;
      cycle();
      repeat (3) cycle();
      chk("overflow_sticky", overflow, 1);
      chk("overflow_count", count, DEPTH);
      out_ready = 1'b1;
      repeat (12) cycle();
      out_ready = 1'b0;
      chk("overflow_after_drain", overflow, 1);

      // Mid-operation reset with 5 buffered and 3 in flight.
      do_reset(1'b0);
      honor = 1'b1;
      launch_valid = 1'b1;
      for (int i = 0; i < 40 && m_fifo.size() != 5; i++) cycle();
      chk("midrst_count_setup", count, 5);
      chk("midrst_inflight_setup", pipe.size() + res_valid, 3);
      #2;
      rst = 1'b0;
      #1;
      chk("midrst_credits", credits, DEPTH);
      chk("midrst_count", count, 0);
      chk("midrst_out_valid", out_valid, 0);
      chk("midrst_launch_ready", launch_ready, 0);
      do_reset(1'b0);
      repeat (10) cycle();
      chk("post_rst_out_valid", out_valid, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
